// File: rtl/tri_raster_if.sv
// Triangle-in / fragment-out handshake bundle for the triangle raster sampler.
// The master side supplies triangles and accepts fragments. The slave side is the sampler.
interface tri_raster_if #(
    parameter int COORD_W = 16
);
    logic signed [COORD_W-1:0] ax, ay, bx, by, cx, cy;
    logic                      winding_order;
    logic                      tri_valid;
    logic                      tri_ready;
    logic                      frag_valid;
    logic                      frag_ready;
    logic signed [COORD_W-1:0] frag_x, frag_y;
    logic                      tri_done;
    logic                      busy;

    modport master (
        output ax, ay, bx, by, cx, cy, winding_order, tri_valid, frag_ready,
        input  tri_ready, frag_valid, frag_x, frag_y, tri_done, busy
    );

    modport slave (
        input  ax, ay, bx, by, cx, cy, winding_order, tri_valid, frag_ready,
        output tri_ready, frag_valid, frag_x, frag_y, tri_done, busy
    );
endinterface

// File: rtl/tri_raster_sampler.sv
// Bounding-box triangle rasterizer: incremental edge functions walk the clipped box
// in row-major order and emit covered pixels through a one-entry output register.
module tri_raster_sampler #(
    parameter int COORD_W   = 16,
    parameter int SCR_W     = 640,
    parameter int SCR_H     = 480,
    parameter bit INCLUSIVE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    tri_raster_if.slave  bus
);
    localparam int EW = 2 * COORD_W + 3;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [EW-1:0]      edge_t;
    typedef enum logic [2:0] {IDLE, SETUP, INIT, SCAN, DRAIN} state_t;

    localparam coord_t X_HI = coord_t'(SCR_W - 1);
    localparam coord_t Y_HI = coord_t'(SCR_H - 1);

    function automatic edge_t widen(input coord_t v);
        return edge_t'(v);
    endfunction

    function automatic coord_t min_s(input coord_t a, input coord_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic coord_t max_s(input coord_t a, input coord_t b);
        return (a > b) ? a : b;
    endfunction

    // Exact in EW bits: each difference needs COORD_W+1, each product 2*COORD_W+2.
    function automatic edge_t edge_fn(input coord_t px, input coord_t py,
                                      input coord_t ux, input coord_t uy,
                                      input coord_t vx, input coord_t vy);
        edge_t dpx, dpy, dvx, dvy;
        dpx = widen(px) - widen(ux);
        dpy = widen(py) - widen(uy);
        dvx = widen(vx) - widen(ux);
        dvy = widen(vy) - widen(uy);
        return dpx * dvy - dpy * dvx;
    endfunction

    function automatic logic covers(input edge_t e0, input edge_t e1, input edge_t e2,
                                    input logic cwise);
        logic n0, n1, n2, z0, z1, z2;
        n0 = e0[EW-1];
        n1 = e1[EW-1];
        n2 = e2[EW-1];
        z0 = (e0 == '0);
        z1 = (e1 == '0);
        z2 = (e2 == '0);
        if (cwise)
            return INCLUSIVE ? ((n0 | z0) & (n1 | z1) & (n2 | z2)) : (n0 & n1 & n2);
        return INCLUSIVE ? (!n0 & !n1 & !n2)
                         : (!n0 & !z0 & !n1 & !z1 & !n2 & !z2);
    endfunction

    state_t state, next;

    coord_t vx [3];
    coord_t vy [3];
    logic   cwise;

    coord_t box_x0, box_x1, box_y0, box_y1;
    coord_t px, py;

    coord_t bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    edge_t  area;
    edge_t  cur_e [3];
    logic   box_empty, hit, advance, last_px, last_py, load, accept;

    logic   fv;
    coord_t fx, fy;
    logic   done_r;

    assign accept  = (state == IDLE) && bus.tri_valid;
    assign advance = !fv || bus.frag_ready;
    assign last_px = (px == box_x1);
    assign last_py = (py == box_y1);
    assign hit     = covers(cur_e[0], cur_e[1], cur_e[2], cwise);
    assign load    = (state == SCAN) && advance && hit;

    // Box is clipped on each side independently so a fully off-screen triangle stays empty.
    always_comb begin
        bb_xmin   = max_s(min_s(min_s(vx[0], vx[1]), vx[2]), coord_t'(0));
        bb_xmax   = min_s(max_s(max_s(vx[0], vx[1]), vx[2]), X_HI);
        bb_ymin   = max_s(min_s(min_s(vy[0], vy[1]), vy[2]), coord_t'(0));
        bb_ymax   = min_s(max_s(max_s(vy[0], vy[1]), vy[2]), Y_HI);
        box_empty = (bb_xmin > bb_xmax) || (bb_ymin > bb_ymax);
        area      = edge_fn(vx[2], vy[2], vx[0], vy[0], vx[1], vy[1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (bus.tri_valid) next = SETUP;
            SETUP:   next = (box_empty || (area == '0)) ? DRAIN : INIT;
            INIT:    next = SCAN;
            SCAN:    if (advance && last_px && last_py) next = DRAIN;
            DRAIN:   if (!fv) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // ---- accept / setup / scan position ----
    always_ff @(posedge clk) begin
        if (accept) begin
            vx[0] <= bus.ax;
            vy[0] <= bus.ay;
            vx[1] <= bus.bx;
            vy[1] <= bus.by;
            vx[2] <= bus.cx;
            vy[2] <= bus.cy;
            cwise <= bus.winding_order;
        end
        if (state == SETUP) begin
            box_x0 <= bb_xmin;
            box_x1 <= bb_xmax;
            box_y0 <= bb_ymin;
            box_y1 <= bb_ymax;
        end
        if (state == INIT) begin
            px <= box_x0;
            py <= box_y0;
        end else if (state == SCAN && advance) begin
            if (last_px) begin
                px <= box_x0;
                py <= py + coord_t'(1);
            end else begin
                px <= px + coord_t'(1);
            end
        end
    end

    // ---- per-edge incremental evaluation (edges ab, bc, ca) ----
    for (genvar k = 0; k < 3; k++) begin : g_edge
        localparam int N = (k + 1) % 3;
        edge_t step_x, step_y, e_cur, e_row, init_e;

        assign init_e   = edge_fn(box_x0, box_y0, vx[k], vy[k], vx[N], vy[N]);
        assign cur_e[k] = e_cur;

        always_ff @(posedge clk) begin
            if (state == SETUP) begin
                step_x <= widen(vy[N]) - widen(vy[k]);
                step_y <= widen(vx[k]) - widen(vx[N]);
            end
            if (state == INIT) begin
                e_cur <= init_e;
                e_row <= init_e;
            end else if (state == SCAN && advance) begin
                if (last_px) begin
                    e_row <= e_row + step_y;
                    e_cur <= e_row + step_y;
                end else begin
                    e_cur <= e_cur + step_x;
                end
            end
        end
    end

    // ---- output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv     <= 1'b0;
            fx     <= '0;
            fy     <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= (state == DRAIN) && (next == IDLE);
            if (load) begin
                fv <= 1'b1;
                fx <= px;
                fy <= py;
            end else if (fv && bus.frag_ready) begin
                fv <= 1'b0;
            end
        end
    end

    assign bus.tri_ready  = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.frag_valid = fv;
    assign bus.frag_x     = fx;
    assign bus.frag_y     = fy;
    assign bus.tri_done   = done_r;
endmodule
